// File: rtl/clock_step_ctrl.sv
// Run/halt/single-step sequencer driving the CPU clock generator's stop_clk_req.
// Latency: a command in cycle k releases stop_clk_req in cycle k+1; halts land on the next whole-cycle boundary.
// Backpressure: none; commands arriving in states that cannot act on them are dropped. Optional macro: CYCLE_COUNT_EN.
module clock_step_ctrl #(
  parameter int STEP_W = 16
`ifdef CYCLE_COUNT_EN
  ,
  parameter int CNT_W  = 32
`endif
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              cmd_run,
  input  logic              cmd_halt,
  input  logic              cmd_step,
  input  logic [STEP_W-1:0] step_count,
  input  logic              brk_halt,
  output logic              stop_clk_req,
  output logic              running,
  output logic              step_done
`ifdef CYCLE_COUNT_EN
  ,
  output logic [CNT_W-1:0]  cycle_count,
  input  logic              clr_cycles
`endif
);

  localparam logic [1:0] S_HALT  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_STEP  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [1:0]      state;
  logic [1:0]      state_nx;
  logic [STEP_W:0] remaining;
  logic [STEP_W:0] remaining_nx;
  logic            phase;
  logic            stop_nx;
  logic            done_nx;
  logic            stop_any;
  logic [STEP_W-1:0] step_eff;
  logic [STEP_W:0]   step_len;

  // Breakpoint and halt share one meaning: stop on the next boundary.
  assign stop_any = cmd_halt | brk_halt;

  // A zero burst length runs one CPU cycle; two clk cycles per CPU cycle.
  // The extra bit on remaining keeps 2*(2^STEP_W-1) representable.
  assign step_eff = (step_count == '0) ? STEP_W'(1) : step_count;
  assign step_len = {step_eff, 1'b0};

  // Next-state, next stop request and step completion for the sequencer.
  always_comb begin
    state_nx     = state;
    remaining_nx = remaining;
    stop_nx      = stop_clk_req;
    done_nx      = 1'b0;
    case (state)
      S_HALT: begin
        stop_nx = 1'b1;
        if (stop_any) begin
          state_nx = S_HALT;
        end else if (cmd_step) begin
          state_nx     = S_STEP;
          remaining_nx = step_len;
          stop_nx      = 1'b0;
        end else if (cmd_run) begin
          state_nx = S_RUN;
          stop_nx  = 1'b0;
        end
      end
      S_RUN: begin
        stop_nx = 1'b0;
        if (stop_any) begin
          // phase=1 now means the clock lands on a boundary after this cycle.
          if (phase) begin
            state_nx = S_HALT;
            stop_nx  = 1'b1;
          end else begin
            state_nx = S_DRAIN;
          end
        end
      end
      S_STEP: begin
        stop_nx      = 1'b0;
        remaining_nx = remaining - (STEP_W+1)'(1);
        if (stop_any) begin
          remaining_nx = '0;
          if (phase) begin
            state_nx = S_HALT;
            stop_nx  = 1'b1;
          end else begin
            state_nx = S_DRAIN;
          end
        end else if (remaining == (STEP_W+1)'(1)) begin
          // Burst lengths are even, so the last cycle always has phase=1.
          state_nx = S_HALT;
          stop_nx  = 1'b1;
          done_nx  = 1'b1;
        end
      end
      S_DRAIN: begin
        state_nx = S_HALT;
        stop_nx  = 1'b1;
      end
      default: begin
        state_nx = S_HALT;
        stop_nx  = 1'b1;
      end
    endcase
  end

  // Registered sequencer state and outputs; reset parks the clock stopped.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state        <= S_HALT;
      remaining    <= '0;
      phase        <= 1'b0;
      stop_clk_req <= 1'b1;
      running      <= 1'b0;
      step_done    <= 1'b0;
    end else begin
      state        <= state_nx;
      remaining    <= remaining_nx;
      phase        <= phase ^ ~stop_clk_req;
      stop_clk_req <= stop_nx;
      running      <= (state_nx != S_HALT);
      step_done    <= done_nx;
    end
  end

`ifdef CYCLE_COUNT_EN
  // Counts completed CPU cycles: the second half of each cycle ends one.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      cycle_count <= '0;
    end else if (clr_cycles) begin
      cycle_count <= '0;
    end else if (!stop_clk_req && phase) begin
      cycle_count <= cycle_count + CNT_W'(1);
    end
  end
`endif

endmodule
